// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared payload width and skid-buffer state encoding for the EX->MEM register (EX_PIPE_DIFFTEST_EN widens the payload)
package ex_mem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic int ex_mem_payload_w(input int xlen, input int reg_aw, input int mask_w);
        int w;
        w = 2 * xlen + reg_aw + mask_w + 4;
`ifdef EX_PIPE_DIFFTEST_EN
        w = w + xlen + 33;
`endif
        return w;
    endfunction

    localparam int EX_MEM_PAYLOAD_W = ex_mem_payload_w(64, 5, 8);

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: valid/ready stage register, single-entry (SKID=0) or 2-entry skid buffer with registered ready (SKID=1)
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter int SKID      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    generate
        if (SKID != 0) begin : g_skid
            skid_state_e          r_state;
            skid_state_e          w_next;
            logic                 r_ready;
            logic [PAYLOAD_W-1:0] r_m;
            logic [PAYLOAD_W-1:0] r_s;
            logic                 w_in;
            logic                 w_out;
            logic                 w_load_m;
            logic                 w_load_s;
            logic                 w_promote;

            assign w_in        = in_valid_i & r_ready;
            assign w_out       = (r_state != ST_EMPTY) & out_ready_i;
            assign in_ready_o  = r_ready;
            assign out_valid_o = r_state != ST_EMPTY;
            assign out_data_o  = r_m;

            // Next state and which register loads; flush overrides everything
            always_comb begin
                w_next    = r_state;
                w_load_m  = 1'b0;
                w_load_s  = 1'b0;
                w_promote = 1'b0;
                if (flush_i) begin
                    w_next = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            w_load_m = w_in;
                            w_next   = w_in ? ST_ONE : ST_EMPTY;
                        end
                        ST_ONE: begin
                            w_load_m = w_in & w_out;
                            w_load_s = w_in & ~w_out;
                            w_next   = (w_in & ~w_out) ? ST_FULL : (~w_in & w_out) ? ST_EMPTY : ST_ONE;
                        end
                        ST_FULL: begin
                            w_promote = w_out;
                            w_next    = w_out ? ST_ONE : ST_FULL;
                        end
                        default: w_next = ST_EMPTY;
                    endcase
                end
            end

            // State register plus ready flop so MEM back-pressure never reaches EX combinationally
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ST_EMPTY;
                    r_ready <= 1'b1;
                end else begin
                    r_state <= w_next;
                    r_ready <= w_next != ST_FULL;
                end
            end

            // Main and skid payload registers; only load on accept or promotion
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_m <= '0;
                    r_s <= '0;
                end else begin
                    if (w_load_m) r_m <= in_data_i;
                    else if (w_promote) r_m <= r_s;
                    if (w_load_s) r_s <= in_data_i;
                end
            end
        end else begin : g_reg
            logic                 r_v;
            logic [PAYLOAD_W-1:0] r_m;
            logic                 w_in;

            assign in_ready_o  = ~r_v | out_ready_i;
            assign w_in        = in_valid_i & in_ready_o & ~flush_i;
            assign out_valid_o = r_v;
            assign out_data_o  = r_m;

            // Valid flag: set on accept, cleared on consume or flush
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_v <= 1'b0;
                else if (flush_i) r_v <= 1'b0;
                else if (w_in) r_v <= 1'b1;
                else if (out_ready_i) r_v <= 1'b0;
            end

            // Payload register loads only on accept
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_m <= '0;
                else if (w_in) r_m <= in_data_i;
            end
        end
    endgenerate

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM stage register with handshake, flush and bubble-qualified controls; EX_PIPE_DIFFTEST_EN adds inst/pc/difftest_flush
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int MASK_W = XLEN / 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   wb_data_o,
    input  logic [REG_AW-1:0] wb_addr_i,
    output logic [REG_AW-1:0] wb_addr_o,
    input  logic              wb_en_i,
    output logic              wb_en_o,
    input  logic              mem_is_signed_i,
    output logic              mem_is_signed_o,
    input  logic              mem_r_en_i,
    output logic              mem_r_en_o,
    input  logic              mem_w_en_i,
    output logic              mem_w_en_o,
    input  logic [MASK_W-1:0] mem_mask_i,
    output logic [MASK_W-1:0] mem_mask_o,
    input  logic [XLEN-1:0]   mem_wr_data_i,
    output logic [XLEN-1:0]   mem_wr_data_o
`ifdef EX_PIPE_DIFFTEST_EN
    ,
    input  logic [31:0]       inst_i,
    output logic [31:0]       inst_o,
    input  logic [XLEN-1:0]   pc_i,
    output logic [XLEN-1:0]   pc_o,
    input  logic              difftest_flush_i,
    output logic              difftest_flush_o
`endif
);

    localparam int PW = ex_mem_payload_w(XLEN, REG_AW, MASK_W);

    logic [PW-1:0] w_in_data;
    logic [PW-1:0] w_out_data;
    logic          w_wb_en;
    logic          w_r_en;
    logic          w_w_en;

`ifdef EX_PIPE_DIFFTEST_EN
    assign w_in_data = {inst_i, pc_i, difftest_flush_i, wb_data_i, wb_addr_i, wb_en_i, mem_is_signed_i,
                        mem_r_en_i, mem_w_en_i, mem_mask_i, mem_wr_data_i};
    assign {inst_o, pc_o, difftest_flush_o, wb_data_o, wb_addr_o, w_wb_en, mem_is_signed_o,
            w_r_en, w_w_en, mem_mask_o, mem_wr_data_o} = w_out_data;
`else
    assign w_in_data = {wb_data_i, wb_addr_i, wb_en_i, mem_is_signed_i, mem_r_en_i, mem_w_en_i,
                        mem_mask_i, mem_wr_data_i};
    assign {wb_data_o, wb_addr_o, w_wb_en, mem_is_signed_o, w_r_en, w_w_en,
            mem_mask_o, mem_wr_data_o} = w_out_data;
`endif

    // Side-effecting controls are zero whenever no valid entry is presented
    assign wb_en_o    = w_wb_en & out_valid_o;
    assign mem_r_en_o = w_r_en & out_valid_o;
    assign mem_w_en_o = w_w_en & out_valid_o;

    pipe_skid_buf #(
        .PAYLOAD_W(PW),
        .SKID     (SKID)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (w_in_data),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (w_out_data)
    );

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX→MEM stage register; successor to the always-enabled EX pipeline register.
- Adds a valid/ready handshake, synchronous flush and bubble-qualified control outputs.
- Adds a selectable full-throughput skid mode so MEM back-pressure never combinationally reaches EX.
- Sits between the execute stage and the LSU/memory stage.

Parameters:
XLEN, 64, datapath width of wb_data and mem_wr_data
REG_AW, 5, register-file address width
MASK_W, XLEN/8, byte-mask width
SKID, 1, 0 = single register with combinational in_ready_o; 1 = 2-entry skid buffer with registered in_ready_o

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous kill of all held and incoming entries
in_valid_i  in  1  EX presents a valid entry
in_ready_o  out  1  stage can accept an entry this cycle
out_valid_o  out  1  entry presented to MEM is valid
out_ready_i  in  1  MEM consumes the presented entry
wb_data_i / wb_data_o  in/out  XLEN  write-back data
wb_addr_i / wb_addr_o  in/out  REG_AW  write-back register index
wb_en_i / wb_en_o  in/out  1  write-back enable; output forced 0 when out_valid_o=0
mem_is_signed_i / mem_is_signed_o  in/out  1  sign-extend load
mem_r_en_i / mem_r_en_o  in/out  1  load enable; output forced 0 when out_valid_o=0
mem_w_en_i / mem_w_en_o  in/out  1  store enable; output forced 0 when out_valid_o=0
mem_mask_i / mem_mask_o  in/out  MASK_W  byte mask
mem_wr_data_i / mem_wr_data_o  in/out  XLEN  store data

Behaviour:
- Reset (async, active-high): all valids cleared, state EMPTY, every payload output 0, out_valid_o=0.
- in_ready_o is 1 in reset in SKID=1 mode, and 1 in SKID=0 mode.
- Transfers:
  - In-transfer = in_valid_i & in_ready_o.
  - Out-transfer = out_valid_o & out_ready_i.
  - Payload fields travel as one atomic entry; no field is ever mixed across entries.
- SKID=0:
  - One register; in_ready_o = !out_valid_o | out_ready_i (combinational).
  - Latency 1 cycle; throughput 1/cycle.
- SKID=1:
  - Main register M drives the outputs; skid register S.
  - States:
    - EMPTY: M and S empty.
    - ONE: M full.
    - FULL: M and S full.
  - in_ready_o = (state != FULL), registered.
  - EMPTY: in-transfer → load M, go to ONE.
  - ONE:
    - in & out → reload M, stay ONE.
    - in & !out → load S, go to FULL.
    - !in & out → go to EMPTY.
  - FULL:
    - out-transfer → S moves to M, go to ONE.
    - No input is accepted in FULL.
  - Latency 1 cycle; sustained throughput 1/cycle with out_ready_i constantly 1.
  - Order is strictly FIFO.
- Flush:
  - flush_i=1 at a clock edge drops M and S and ignores that cycle's in-transfer.
  - Next state is EMPTY and out_valid_o=0.
  - Flush has priority over every other event.
  - Payload registers need not clear; qualified controls go 0 via out_valid_o.
- Bubbles:
  - When out_valid_o=0, wb_en_o, mem_r_en_o and mem_w_en_o are 0.
  - Other payload outputs hold their last value.
- Hold: out_valid_o=1 & out_ready_i=0 keeps all outputs stable.
- Data registers update only on in-transfer or skid promotion; this saves power.

Optional Feature:
- EX_PIPE_DIFFTEST_EN defined:
  - Adds inst_i/inst_o (32), pc_i/pc_o (XLEN) and difftest_flush_i/difftest_flush_o (1).
  - These carry in the same entry, reset to 0, and are not bubble-forced.
- Undefined: these ports and their registers are absent.

Decomposition:
- Shared package ex_mem_pkg:
  - Payload struct/width constant EX_MEM_PAYLOAD_W, derived from XLEN/REG_AW/MASK_W and the difftest macro.
  - Skid state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
- One natural sub-module: pipe_skid_buf.
  - Generic over PAYLOAD_W and SKID; handles valid/ready/flush.
  - The top packs/unpacks the payload and applies bubble forcing.

Test Plan:
- Reset: assert rst mid-stream with M,S full → out_valid_o=0, all outputs 0, immediately without a clock edge.
- Stream: in_valid_i=1, out_ready_i=1, wb_data_i=1..8 → wb_data_o=1..8 on consecutive cycles, one cycle late, no gaps.
- Back-pressure (SKID=1):
  - out_ready_i=0 for 3 cycles while sending 0xA,0xB,0xC.
  - Expect FULL after 0xB and in_ready_o=0.
  - 0xC is held at EX; after release the output order is A,B,C.
- Flush in FULL with in_valid_i=1 → next cycle out_valid_o=0, wb_en_o=0, mem_w_en_o=0; the incoming entry is not seen.
- Bubble: store entry (mem_w_en_i=1, mask 8'h0F, data 0xDEADBEEF) then idle → mem_w_en_o=1 for one transfer, then 0 while mem_mask_o holds 8'h0F.
- SKID=0 with out_ready_i=0 and out_valid_o=1 → in_ready_o=0 in the same cycle; raising out_ready_i raises in_ready_o combinationally.
